// File: rtl/first_system_pkg.sv
// Shared types and constants for the first_system stimulus sequencer:
// the controller state encoding and the fixed table of {in1,in2} vectors.
package first_system_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAX_SEQ = 7;
  localparam int RESP_W  = 2 * MAX_SEQ;

  // Vectors played as {in1,in2}, one per step.
  localparam logic [1:0] VEC_TABLE [MAX_SEQ] = '{
    2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11
  };

  // Table lookup that yields 00 for any index past the end of the table,
  // so the idle/quiet vector is what a stray index produces.
  function automatic logic [1:0] table_vec(input logic [2:0] idx);
    logic [1:0] v;
    v = 2'b00;
    if (int'(idx) < MAX_SEQ) begin
      v = VEC_TABLE[idx];
    end
    return v;
  endfunction

endpackage

// File: rtl/first_system_stim_dwell_counter.sv
// Dwell counter: counts the cycles a vector has been held and flags the
// last cycle of the dwell. Clear wins over enable.
module dwell_counter #(
  parameter int DWELL = 10,
  parameter int WIDTH = $clog2(DWELL + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic terminal
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(DWELL - 1);

  logic [WIDTH-1:0] count;

  // Count register: reset and clear both return to zero, enable steps by one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/first_system_stim.sv
// Stimulus sequencer: plays a fixed table of {in1,in2} vectors to a
// downstream block, holding each for DWELL cycles, and captures the
// {obs1,obs2} response at the end of each dwell into resp.
module first_system_stim
  import first_system_pkg::*;
#(
  parameter int DWELL   = 10,
  parameter int SEQ_LEN = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  input  logic              obs1,
  input  logic              obs2,
  output logic              in1,
  output logic              in2,
  output logic [2:0]        step,
  output logic              busy,
  output logic              done,
  output logic [RESP_W-1:0] resp
);

  localparam logic [2:0] LAST_STEP = 3'(SEQ_LEN - 1);

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        step_nxt;
  logic [1:0]        vec_nxt;
  logic              done_nxt;
  logic              busy_nxt;
  logic [RESP_W-1:0] resp_nxt;
  logic              cnt_en;
  logic              cnt_clr;
  logic              cnt_tc;

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (cnt_en),
    .clear    (cnt_clr),
    .terminal (cnt_tc)
  );

  // Next-state and next-output logic. RUN and PAUSE share one branch: the
  // state only records whether the last cycle was frozen, and a cycle with
  // pause low does the normal dwell work whichever of the two it started in.
  // That way each cycle pause is held costs exactly one cycle of delay.
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    vec_nxt   = {in1, in2};
    done_nxt  = 1'b0;
    resp_nxt  = resp;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;

    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start && !abort) begin
          state_nxt = RUN;
          step_nxt  = 3'd0;
          vec_nxt   = table_vec(3'd0);
          resp_nxt  = '0;
          cnt_clr   = 1'b1;
        end
      end

      RUN, PAUSE: begin
        if (abort) begin
          state_nxt = IDLE;
          step_nxt  = 3'd0;
          vec_nxt   = 2'b00;
          cnt_clr   = 1'b1;
        end else if (pause) begin
          state_nxt = PAUSE;
        end else begin
          state_nxt = RUN;
          if (cnt_tc) begin
            for (int k = 0; k < MAX_SEQ; k++) begin
              if (step == 3'(k)) begin
                resp_nxt[2*k +: 2] = {obs1, obs2};
              end
            end
            cnt_clr = 1'b1;
            if (step == LAST_STEP) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
              step_nxt  = 3'd0;
              vec_nxt   = 2'b00;
            end else begin
              step_nxt = step + 3'd1;
              vec_nxt  = table_vec(step + 3'd1);
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        step_nxt  = 3'd0;
        vec_nxt   = 2'b00;
        cnt_clr   = 1'b1;
      end
    endcase

    busy_nxt = (state_nxt == RUN) || (state_nxt == PAUSE);
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      in1   <= 1'b0;
      in2   <= 1'b0;
      step  <= 3'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      resp  <= '0;
    end else begin
      state      <= state_nxt;
      {in1, in2} <= vec_nxt;
      step       <= step_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      resp       <= resp_nxt;
    end
  end

endmodule

// File: tb/tb_first_system_stim.sv
// Bench for first_system_stim: two instances (DWELL=10/SEQ_LEN=7 and
// DWELL=1/SEQ_LEN=4) driven through directed and random runs. A reference
// model based on elapsed active cycles predicts every cycle's outputs, and
// the end of each run is checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_first_system_stim;

  localparam int D0 = 10;
  localparam int L0 = 7;
  localparam int D1 = 1;
  localparam int L1 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] start_v = '0;
  logic [1:0] pause_v = '0;
  logic [1:0] abort_v = '0;
  logic [1:0] obs1_v;
  logic [1:0] obs2_v;
  logic [1:0] in1_v;
  logic [1:0] in2_v;
  logic [1:0] busy_v;
  logic [1:0] done_v;
  logic [1:0][1:0]  mask_v = '0;
  logic [1:0][2:0]  step_v;
  logic [1:0][13:0] resp_v;
  logic [1:0][13:0] last_resp = '0;
  logic [1:0] busy_prev = '0;

  int total = 0;
  int bad = 0;
  longint cyc = 0;

  typedef struct {
    int          inst;
    bit          is_done;
    logic [13:0] resp;
    longint      at;
  } exp_t;

  exp_t sbq[$];

  first_system_stim #(.DWELL(D0), .SEQ_LEN(L0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .pause(pause_v[0]),
    .abort(abort_v[0]), .obs1(obs1_v[0]), .obs2(obs2_v[0]),
    .in1(in1_v[0]), .in2(in2_v[0]), .step(step_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .resp(resp_v[0])
  );

  first_system_stim #(.DWELL(D1), .SEQ_LEN(L1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .pause(pause_v[1]),
    .abort(abort_v[1]), .obs1(obs1_v[1]), .obs2(obs2_v[1]),
    .in1(in1_v[1]), .in2(in2_v[1]), .step(step_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .resp(resp_v[1])
  );

  // Downstream stand-in: out1 = AND, out2 = XOR, optionally inverted per run.
  assign obs1_v[0] = (in1_v[0] & in2_v[0]) ^ mask_v[0][1];
  assign obs2_v[0] = (in1_v[0] ^ in2_v[0]) ^ mask_v[0][0];
  assign obs1_v[1] = (in1_v[1] & in2_v[1]) ^ mask_v[1][1];
  assign obs2_v[1] = (in1_v[1] ^ in2_v[1]) ^ mask_v[1][0];

  always #5 clk = ~clk;

  // Free-running cycle count used to time-stamp expected events.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dwell_of(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  function automatic int len_of(input int i);
    return (i == 0) ? L0 : L1;
  endfunction

  function automatic logic [1:0] vec_of(input int k);
    case (k)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b10;
      3: return 2'b11;
      4: return 2'b01;
      5: return 2'b10;
      6: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Response image after the first nsteps vectors have been captured.
  function automatic logic [13:0] resp_after(input int nsteps, input logic [1:0] mask);
    logic [13:0] r;
    logic [1:0]  v;
    r = '0;
    for (int k = 0; k < nsteps; k++) begin
      v = vec_of(k);
      r[2*k +: 2] = {v[1] & v[0], v[1] ^ v[0]} ^ mask;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // One run on instance i. Event positions are in active (non-paused) cycles
  // since start; -1 means the event is not used. Called and returns just
  // after a falling edge.
  task automatic applyStimulus(input int i, input int pause_at, input int plen,
                               input int abort_at, input int rst_at,
                               input int spur_at, input logic [1:0] mask);
    int   d, l, e, pleft, end_e, pcount, act;
    bit   fin;
    exp_t x;
    d = dwell_of(i);
    l = len_of(i);
    mask_v[i]  = mask;
    start_v[i] = 1'b1;

    end_e  = (abort_at >= 0) ? abort_at : (rst_at >= 0) ? rst_at : d * l;
    pcount = (pause_at >= 0 && pause_at <= end_e) ? plen : 0;
    x.inst    = i;
    x.is_done = (abort_at < 0) && (rst_at < 0);
    x.resp    = (rst_at >= 0) ? 14'd0 : resp_after(x.is_done ? l : end_e / d, mask);
    x.at      = cyc + end_e + pcount + (x.is_done ? 1 : 2);
    sbq.push_back(x);
    if (rst_at >= 0) last_resp = '0;
    else last_resp[i] = x.resp;

    @(negedge clk);
    start_v[i] = 1'b0;
    e = 0;
    pleft = plen;
    fin = 1'b0;
    for (int g = 0; g < 4000 && !fin; g++) begin
      checkOutput("busy", busy_v[i], 1);
      checkOutput("done_early", done_v[i], 0);
      checkOutput("step", step_v[i], e / d);
      checkOutput("vec", {in1_v[i], in2_v[i]}, vec_of(e / d));
      act = 0;
      if (pause_at == e && pleft > 0) begin
        pause_v[i] = 1'b1;
        pleft--;
        act = 1;
      end else if (abort_at == e) begin
        abort_v[i] = 1'b1;
        act = 2;
      end else if (rst_at == e) begin
        rst_n = 1'b0;
        act = 3;
      end else if (spur_at == e) begin
        start_v[i] = 1'b1;
      end
      @(negedge clk);
      pause_v[i] = 1'b0;
      abort_v[i] = 1'b0;
      start_v[i] = 1'b0;
      rst_n = 1'b1;
      if (act >= 2) begin
        fin = 1'b1;
        checkOutput("stop_busy", busy_v[i], 0);
        checkOutput("stop_done", done_v[i], 0);
        checkOutput("stop_step", step_v[i], 0);
        checkOutput("stop_vec", {in1_v[i], in2_v[i]}, 0);
        if (act == 3) checkOutput("rst_resp", resp_v[i], 0);
      end else if (act == 0) begin
        e++;
        if (e == d * l) begin
          fin = 1'b1;
          checkOutput("end_done", done_v[i], 1);
          checkOutput("end_busy", busy_v[i], 0);
          checkOutput("end_step", step_v[i], 0);
          checkOutput("end_vec", {in1_v[i], in2_v[i]}, 0);
        end
      end
    end
    checkOutput("run_bound", fin, 1);
  endtask

  // start together with abort while not running: nothing may change.
  task automatic idleStartAbort(input int i);
    start_v[i] = 1'b1;
    abort_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    abort_v[i] = 1'b0;
    checkOutput("sa_busy", busy_v[i], 0);
    checkOutput("sa_done", done_v[i], 0);
    checkOutput("sa_step", step_v[i], 0);
    checkOutput("sa_vec", {in1_v[i], in2_v[i]}, 0);
    checkOutput("sa_resp", resp_v[i], last_resp[i]);
  endtask

  // Monitor: a done pulse or busy dropping ends a run; match it to the queue.
  always @(negedge clk) begin
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      if (done_v[i] === 1'b1 || (busy_prev[i] === 1'b1 && busy_v[i] === 1'b0)) begin
        if (sbq.size() == 0) begin
          checkOutput("sb_unexpected", sbq.size(), 1);
        end else begin
          x = sbq.pop_front();
          checkOutput("sb_inst", i, x.inst);
          checkOutput("sb_kind", done_v[i], x.is_done);
          checkOutput("sb_resp", resp_v[i], x.resp);
          checkOutput("sb_time", cyc[31:0], x.at[31:0]);
        end
      end
      busy_prev[i] <= busy_v[i];
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached, total=%0d", total);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput("rst_busy", busy_v[i], 0);
      checkOutput("rst_done", done_v[i], 0);
      checkOutput("rst_step", step_v[i], 0);
      checkOutput("rst_vec", {in1_v[i], in2_v[i]}, 0);
      checkOutput("rst_resp", resp_v[i], 0);
    end
    rst_n = 1'b1;

    applyStimulus(0, -1, 0, -1, -1, -1, 2'b00);
    applyStimulus(1, -1, 0, -1, -1, -1, 2'b00);
    applyStimulus(0, 29, 5, -1, -1, -1, 2'b00);
    applyStimulus(0, -1, 0, 30, -1, -1, 2'b00);
    applyStimulus(0, -1, 0, -1, 42, -1, 2'b00);
    applyStimulus(0, -1, 0, -1, -1, 15, 2'b00);
    idleStartAbort(0);
    idleStartAbort(1);
    applyStimulus(1, 2, 3, -1, -1, 1, 2'b11);

    for (int r = 0; r < 16; r++) begin
      int i, d, l, pa, pl, ab, sp, sc;
      logic [1:0] m;
      i  = int'($urandom_range(0, 1));
      d  = dwell_of(i);
      l  = len_of(i);
      m  = 2'($urandom_range(0, 3));
      sc = int'($urandom_range(0, 3));
      pa = -1;
      pl = 0;
      ab = -1;
      sp = -1;
      if (sc == 1 || sc == 3) begin
        pa = int'($urandom_range(0, d * l - 1));
        pl = int'($urandom_range(1, 6));
      end
      if (sc >= 2) ab = int'($urandom_range(0, d * l - 1));
      if ($urandom_range(0, 1) == 1) sp = int'($urandom_range(0, d * l - 1));
      applyStimulus(i, pa, pl, ab, -1, sp, m);
      if ($urandom_range(0, 3) == 0) idleStartAbort(i);
    end

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
